// File: rtl/bus_rd_collector.sv
// rtl/bus_rd_collector.sv - CPU read sequencer: strobe devices, collect registered select/data, ack or open-bus 0xFF
// Optional feature: define BUS_CONFLICT_DETECT_EN for the sticky multi-select flag on oConflict.
module bus_rd_collector #(
    parameter int NUM_DEV = 4,
    parameter int TIMEOUT = 3
) (
    input  logic                   iClk,
    input  logic                   iRst_n,
    input  logic [19:0]            iCpuAddr,
    input  logic                   iCpuRd,
    output logic [7:0]             oCpuData,
    output logic                   oCpuAck,
    output logic [19:0]            oAddr,
    output logic                   oRd,
    input  logic [NUM_DEV-1:0]     iSel,
    input  logic [8*NUM_DEV-1:0]   iData,
    output logic                   oConflict
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_cpu_data;
    logic               r_cpu_ack;
    logic [19:0]        r_addr;
    logic               r_rd;
    logic               w_any_sel;
    logic               w_timeout;
    logic [7:0]         w_sel_data;

    assign w_any_sel = |iSel;
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

    // Scan from the top down so the lowest selected index is the last write and wins.
    always_comb begin
        w_sel_data = 8'hFF;
        for (int k = NUM_DEV - 1; k >= 0; k--) begin
            if (iSel[k]) begin
                w_sel_data = iData[8*k +: 8];
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (iCpuRd) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (w_any_sel || w_timeout) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_cnt      <= '0;
            r_cpu_data <= 8'hFF;
            r_cpu_ack  <= 1'b0;
            r_addr     <= 20'h0;
            r_rd       <= 1'b0;
        end else begin
            r_rd      <= 1'b0;
            r_cpu_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (iCpuRd) begin
                        r_addr <= iCpuAddr;
                        r_rd   <= 1'b1;
                    end
                end
                S_ISSUE: r_cnt <= '0;
                S_WAIT: begin
                    if (w_any_sel) begin
                        r_cpu_data <= w_sel_data;
                        r_cpu_ack  <= 1'b1;
                    end else if (w_timeout) begin
                        r_cpu_data <= 8'hFF;
                        r_cpu_ack  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BUS_CONFLICT_DETECT_EN
    logic r_conflict;
    logic w_multi_sel;

    // More than one bit set iff clearing the lowest set bit leaves something behind.
    assign w_multi_sel = |(iSel & (iSel - NUM_DEV'(1)));

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_conflict <= 1'b0;
        end else if (r_state == S_WAIT && w_multi_sel) begin
            r_conflict <= 1'b1;
        end
    end

    assign oConflict = r_conflict;
`else
    assign oConflict = 1'b0;
`endif

    assign oCpuData = r_cpu_data;
    assign oCpuAck  = r_cpu_ack;
    assign oAddr    = r_addr;
    assign oRd      = r_rd;

endmodule

// File: doc/bus_rd_collector.md
# bus_rd_collector

Read-cycle sequencer between the CPU bus front end and the memory-mapped read devices (BIOS ROM, option ROMs, other registered read ports). It accepts a CPU read request, issues a one-cycle read strobe with the latched address to all devices in parallel, and collects their registered select/data responses. It returns the winning byte to the CPU with an acknowledge pulse, or open-bus 0xFF after a timeout.

## Interface
- NUM_DEV, 4: number of attached read devices (1..8).
- TIMEOUT, 3: number of WAIT-state cycles iSel is sampled before open-bus is returned (≥1).
- iClk  in  1  system clock; all logic on rising edge.
- iRst_n  in  1  synchronous active-low reset.
- iCpuAddr  in  20  CPU read address; sampled with iCpuRd.
- iCpuRd  in  1  one-cycle read request pulse.
- oCpuData  out  8  returned read byte; held until the next ack.
- oCpuAck  out  1  one-cycle pulse; oCpuData valid in the same cycle.
- oAddr  out  20  latched address to devices.
- oRd  out  1  one-cycle read strobe to devices.
- iSel  in  NUM_DEV  per-device select, registered in device, valid the cycle after oRd.
- iData  in  8*NUM_DEV  packed device data; device k on bits [8k+7:8k].
- oConflict  out  1  sticky multi-select flag (see Configuration).

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: iCpuRd=1 → latch iCpuAddr into oAddr, go to ISSUE. iCpuRd=0 → stay.
- ISSUE: oRd=1 for exactly this cycle; clear the wait counter; go to WAIT.
- WAIT: sample iSel every cycle.
  - Any bit set → capture the data of the lowest set index into oCpuData, pulse oCpuAck next cycle, go to IDLE.
  - No bits set and counter = TIMEOUT-1 → load oCpuData=8'hFF, pulse oCpuAck, go to IDLE.
  - Otherwise → increment the counter.
- Counter width: $clog2(TIMEOUT+1); it never wraps.
- iCpuRd asserted in ISSUE or WAIT is dropped: no queueing, no ack.
- iCpuRd in the ack cycle: accepted, because the FSM is in IDLE.
- iSel seen in IDLE or ISSUE is ignored. A late select after a timeout has no effect.
- Simultaneous selects: the lowest index wins.
- oAddr holds its value between requests.
- Reset values: state IDLE, oRd=0, oCpuAck=0, oCpuData=8'hFF, oAddr=0, counter=0, oConflict=0.
- Reset asserted mid-operation: the next edge forces all reset values. The pending read is abandoned and produces no ack.

## Timing
- Cycle 0: iCpuRd=1 sampled in IDLE.
- Cycle 1: ISSUE, oRd=1, oAddr valid.
- Cycle 2: first WAIT sample. A device responding immediately (as the BIOS ROM does) makes this cycle carry the select.
- Cycle 3: oCpuAck=1 with data. Minimum latency is 3 cycles; back-to-back reads can start every 3 cycles.
- Response in the n-th WAIT cycle (n ≤ TIMEOUT): ack in cycle 2+n.
- No response: ack with 0xFF in cycle TIMEOUT+2.
- All outputs are registered; no combinational path from iSel/iData to the CPU outputs.

## Configuration
- BUS_CONFLICT_DETECT_EN defined:
  - Any WAIT-cycle sample with more than one iSel bit set sets oConflict=1.
  - oConflict stays 1 until reset.
  - Data selection is still lowest-index-wins.
- BUS_CONFLICT_DETECT_EN undefined:
  - oConflict is tied to 0.
  - No popcount/detect logic is synthesized.

## Test plan
- BIOS read: iCpuAddr=20'hFFFF0, device 0 returns sel with data 8'hEA in cycle 2 → oRd=1 in cycle 1 only, oCpuAck=1 in cycle 3, oCpuData=8'hEA.
- Unmapped read: iCpuAddr=20'h50000, no selects, TIMEOUT=3 → oCpuAck=1 in cycle 5, oCpuData=8'hFF, single ack.
- Slow device: device 2 asserts sel in the 2nd WAIT cycle with 8'h5A → ack in cycle 4, data 8'h5A.
- Conflict: devices 1 and 3 select together (8'h11, 8'h33) → oCpuData=8'h11. oConflict=1 with the macro and stays set across further clean reads; oConflict=0 without the macro.
- Busy drop: second iCpuRd pulse in cycle 2 → exactly one ack (cycle 3). A request pulse in cycle 3 is accepted, with its ack in cycle 6.
- Reset mid-WAIT: iRst_n=0 during cycle 2 with a select present → no ack, oCpuData=8'hFF, oRd=0. The next request completes normally.
